// File: rtl/uart_rx_fifo_if.sv
// Receive-side bus of uart_rx_fifo: serial input, FIFO read port and sticky error flags.
// The break_det flag exists only when UART_RX_BREAK_DETECT_EN is defined.
interface uart_rx_fifo_if #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned FIFO_DEPTH = 16
);
    logic                          uart_rx;
    logic                          rd_en;
    logic [DATA_BITS-1:0]          rd_data;
    logic                          rd_valid;
    logic [$clog2(FIFO_DEPTH):0]   fifo_count;
    logic                          err_clr;
    logic                          framing_err;
    logic                          parity_err;
    logic                          overrun_err;
`ifdef UART_RX_BREAK_DETECT_EN
    logic                          break_det;
`endif

    // Receiver side
    modport slave (
`ifdef UART_RX_BREAK_DETECT_EN
        output break_det,
`endif
        input  uart_rx, rd_en, err_clr,
        output rd_data, rd_valid, fifo_count, framing_err, parity_err, overrun_err
    );

    // Line driver / consumer side
    modport master (
`ifdef UART_RX_BREAK_DETECT_EN
        input  break_det,
`endif
        output uart_rx, rd_en, err_clr,
        input  rd_data, rd_valid, fifo_count, framing_err, parity_err, overrun_err
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// Oversampled UART receiver with 3-sample majority vote, configurable frame format,
// first-word fall-through receive FIFO and sticky error flags.
// Optional: define UART_RX_BREAK_DETECT_EN to add break detection (break_det).
module uart_rx_fifo #(
    parameter int unsigned CLK_FREQ   = 100000000,
    parameter int unsigned BAUD_RATE  = 9600,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input logic           clk,
    input logic           reset,
    uart_rx_fifo_if.slave bus
);
    localparam int unsigned DIV   = (CLK_FREQ + (BAUD_RATE * OVERSAMPLE) / 2) /
                                    (BAUD_RATE * OVERSAMPLE);
    localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned OS_W  = $clog2(OVERSAMPLE);
    localparam int unsigned BIT_W = $clog2(DATA_BITS + 1);
    localparam int unsigned AW    = $clog2(FIFO_DEPTH);
    localparam int unsigned CW    = AW + 1;

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop, StBreak} state_t;

    logic rx_meta_q, rx_sync_q, rx_prev_q;
    state_t state_q, state_d;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [OS_W-1:0] samp_cnt_q, samp_cnt_d;
    logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic stop_cnt_q, stop_cnt_d;
    logic s0_q, s0_d, s1_q, s1_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic par_bad_q, par_bad_d, frm_bad_q, frm_bad_d, all_zero_q, all_zero_d;
    logic done_q, done_d, done_frm_q, done_frm_d, done_par_q, done_par_d;
    logic done_brk_q, done_brk_d;
    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [DATA_BITS-1:0] mem_d [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic frm_err_q, frm_err_d, par_err_q, par_err_d, ovr_err_q, ovr_err_d;
    logic brk_q, brk_d;

    logic tick, fall, at_s0, at_s1, at_vote, at_end, vote, exp_par;
    logic good, full, push, pop;

    assign tick    = (div_cnt_q == DIV_W'(DIV - 1));
    assign fall    = rx_prev_q & ~rx_sync_q;
    assign at_s0   = tick && (samp_cnt_q == OS_W'(OVERSAMPLE / 2 - 1));
    assign at_s1   = tick && (samp_cnt_q == OS_W'(OVERSAMPLE / 2));
    assign at_vote = tick && (samp_cnt_q == OS_W'(OVERSAMPLE / 2 + 1));
    assign at_end  = tick && (samp_cnt_q == OS_W'(OVERSAMPLE - 1));
    assign vote    = (s0_q & s1_q) | (s0_q & rx_sync_q) | (s1_q & rx_sync_q);
    assign exp_par = (PARITY == 1) ? ~(^shift_q) : (^shift_q);

    // Two-flop synchroniser plus one delayed copy for falling-edge detection
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= bus.uart_rx;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    // Frame decoder: tick/sample counters, majority vote and bit sequencing
    always_comb begin
        state_d    = state_q;
        div_cnt_d  = tick ? '0 : div_cnt_q + DIV_W'(1);
        samp_cnt_d = samp_cnt_q;
        if (tick) samp_cnt_d = at_end ? '0 : samp_cnt_q + OS_W'(1);
        s0_d       = at_s0 ? rx_sync_q : s0_q;
        s1_d       = at_s1 ? rx_sync_q : s1_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        par_bad_d  = par_bad_q;
        frm_bad_d  = frm_bad_q;
        // Only meaningful for votes after the start bit; a start vote of 1 aborts the frame
        all_zero_d = at_vote ? (all_zero_q & ~vote) : all_zero_q;
        done_d     = 1'b0;
        done_frm_d = 1'b0;
        done_par_d = 1'b0;
        done_brk_d = 1'b0;
        case (state_q)
            StIdle: begin
                if (fall) begin
                    state_d    = StStart;
                    div_cnt_d  = '0;
                    samp_cnt_d = '0;
                    bit_cnt_d  = '0;
                    stop_cnt_d = 1'b0;
                    par_bad_d  = 1'b0;
                    frm_bad_d  = 1'b0;
                    all_zero_d = 1'b1;
                end
            end
            StStart: begin
                if (at_vote && vote) state_d = StIdle;
                else if (at_end) state_d = StData;
            end
            StData: begin
                if (at_vote) begin
                    shift_d   = {vote, shift_q[DATA_BITS-1:1]};
                    bit_cnt_d = bit_cnt_q + BIT_W'(1);
                end
                if (at_end && bit_cnt_q == BIT_W'(DATA_BITS)) begin
                    state_d = (PARITY != 0) ? StParity : StStop;
                end
            end
            StParity: begin
                if (at_vote) par_bad_d = (vote != exp_par);
                if (at_end) state_d = StStop;
            end
            StStop: begin
                if (at_vote) begin
                    if (stop_cnt_q == 1'(STOP_BITS - 1)) begin
                        // Leave mid-bit so a back-to-back start edge is not missed
                        state_d    = StIdle;
                        done_d     = 1'b1;
                        done_frm_d = frm_bad_q | ~vote;
                        done_par_d = par_bad_q;
`ifdef UART_RX_BREAK_DETECT_EN
                        if (all_zero_q && !vote) begin
                            state_d    = StBreak;
                            samp_cnt_d = '0;
                            done_frm_d = 1'b0;
                            done_par_d = 1'b0;
                            done_brk_d = 1'b1;
                        end
`endif
                    end else begin
                        frm_bad_d  = frm_bad_q | ~vote;
                        stop_cnt_d = 1'b1;
                    end
                end
            end
`ifdef UART_RX_BREAK_DETECT_EN
            StBreak: begin
                // Wait for one full bit time of continuous idle-high line
                if (tick && !rx_sync_q) samp_cnt_d = '0;
                else if (at_end) state_d = StIdle;
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    // Receive FIFO and sticky error flags, updated from the registered frame result
    always_comb begin
        good      = done_q & ~done_frm_q & ~done_par_q;
        full      = (count_q == CW'(FIFO_DEPTH));
        pop       = bus.rd_en && (count_q != '0);
        push      = good && (!full || bus.rd_en);
        mem_d     = mem_q;
        if (push) mem_d[wr_ptr_q] = shift_q;
        wr_ptr_d  = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d  = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d   = count_q + CW'(push) - CW'(pop);
        frm_err_d = (done_q & done_frm_q) | (frm_err_q & ~bus.err_clr);
        par_err_d = (done_q & done_par_q) | (par_err_q & ~bus.err_clr);
        ovr_err_d = (good & full & ~bus.rd_en) | (ovr_err_q & ~bus.err_clr);
        brk_d     = done_brk_q | (brk_q & ~bus.err_clr);
    end

    // State registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            div_cnt_q  <= '0;
            samp_cnt_q <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            s0_q       <= 1'b1;
            s1_q       <= 1'b1;
            shift_q    <= '0;
            par_bad_q  <= 1'b0;
            frm_bad_q  <= 1'b0;
            all_zero_q <= 1'b0;
            done_q     <= 1'b0;
            done_frm_q <= 1'b0;
            done_par_q <= 1'b0;
            done_brk_q <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            frm_err_q  <= 1'b0;
            par_err_q  <= 1'b0;
            ovr_err_q  <= 1'b0;
            brk_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_cnt_q  <= div_cnt_d;
            samp_cnt_q <= samp_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            s0_q       <= s0_d;
            s1_q       <= s1_d;
            shift_q    <= shift_d;
            par_bad_q  <= par_bad_d;
            frm_bad_q  <= frm_bad_d;
            all_zero_q <= all_zero_d;
            done_q     <= done_d;
            done_frm_q <= done_frm_d;
            done_par_q <= done_par_d;
            done_brk_q <= done_brk_d;
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            frm_err_q  <= frm_err_d;
            par_err_q  <= par_err_d;
            ovr_err_q  <= ovr_err_d;
            brk_q      <= brk_d;
        end
    end

    assign bus.rd_data     = mem_q[rd_ptr_q];
    assign bus.rd_valid    = (count_q != '0);
    assign bus.fifo_count  = count_q;
    assign bus.framing_err = frm_err_q;
    assign bus.parity_err  = par_err_q;
    assign bus.overrun_err = ovr_err_q;
`ifdef UART_RX_BREAK_DETECT_EN
    assign bus.break_det   = brk_q;
`endif
endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Parametrised UART receiver with oversampled, majority-voted bit recovery, configurable frame format and a receive FIFO with sticky error flags. Replaces the fixed 8N1 receive path feeding top_level. The error flags map onto the UART error field of debug_data_out. Default parameters reproduce the 9600-baud, 8N1, 100 MHz link the system bench drives.

Parameters:
CLK_FREQ, 100000000, system clock frequency in Hz
BAUD_RATE, 9600, line rate in bits per second
OVERSAMPLE, 16, sample ticks per bit; even, minimum 8
DATA_BITS, 8, data bits per frame, 5 to 9
PARITY, 0, parity mode: 0 none, 1 odd, 2 even
STOP_BITS, 1, number of stop bits, 1 or 2
FIFO_DEPTH, 16, receive FIFO entries; power of two, minimum 2

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
uart_rx  input  1  serial line, idle high, asynchronous to clk
rd_en  input  1  pop the head entry; ignored when rd_valid=0
rd_data  output  DATA_BITS  FIFO head entry (first-word fall-through)
rd_valid  output  1  FIFO not empty
fifo_count  output  $clog2(FIFO_DEPTH)+1  number of occupied entries
err_clr  input  1  clears all sticky error flags
framing_err  output  1  sticky; a stop bit was sampled low
parity_err  output  1  sticky; parity mismatch
overrun_err  output  1  sticky; a good frame was dropped because the FIFO was full

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; synchroniser flops=1; FIFO empty; rd_data=0; rd_valid=0; fifo_count=0; all error flags=0. Reset asserted mid-frame discards the partial frame.
- Synchroniser: 2-FF synchroniser on uart_rx. All decoding uses the synchronised signal.
- Tick generator:
  - Divider DIV = round(CLK_FREQ / (BAUD_RATE*OVERSAMPLE)); default 651.
  - Produces a one-cycle tick every DIV clocks.
  - Free-running in IDLE. Restarted on the falling edge that moves the FSM to START.
- Sampling: each bit is decided by majority vote of the samples at ticks OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1 within the bit.
- State machine:
  - IDLE -> START on a high-to-low transition of the synchronised line.
  - START: if the voted start bit is 1 (glitch), return to IDLE with no flag. Otherwise -> DATA at the end of the bit.
  - DATA: DATA_BITS bits, LSB first, shifted in. Then -> PARITY if PARITY!=0, else -> STOP.
  - PARITY: compute the expected bit (odd: XOR of data inverted; even: XOR of data) and compare with the voted bit; latch a mismatch. -> STOP.
  - STOP: STOP_BITS bits; any voted 0 latches a framing error. Leave to IDLE at the vote point (mid-bit) of the final stop bit so a back-to-back start edge is caught.
- Frame completion (the cycle after the final stop vote):
  - Framing or parity error: set the corresponding sticky flag(s); frame not pushed.
  - Good frame, FIFO not full, or full with rd_en=1 in the same cycle: push.
  - Good frame, FIFO full, rd_en=0: drop the frame; set overrun_err.
- FIFO:
  - Data appears on rd_data, with rd_valid=1, one cycle after the push.
  - Pop on rd_en && rd_valid; rd_data shows the next entry the following cycle.
  - Simultaneous push and pop: fifo_count unchanged; ordering preserved.
  - Pointers wrap modulo FIFO_DEPTH.
  - rd_en while empty: no effect; fifo_count never underflows.
- Sticky flags: err_clr clears all flags. A set event in the same cycle as err_clr wins (flag stays 1).

Optional Feature:
UART_RX_BREAK_DETECT_EN
- Defined:
  - Adds output break_det (1 bit, sticky, cleared by err_clr, reset 0).
  - A frame whose data bits, parity bit and stop bits all vote 0 sets break_det instead of framing_err; nothing is pushed.
  - The FSM then waits in a BREAK state until the line has been high for one full bit time, then returns to IDLE.
- Not defined: no break_det port; an all-zero frame is treated as an ordinary framing error and the FSM returns to IDLE at the stop vote.

Test Plan:
- Defaults, send 0xAA at 104160 ns/bit -> rd_valid rises about 9.5 bit times after the start edge; rd_data=0xAA; fifo_count=1; no flags.
- Send 0xAA, 0xCC, 0xF0 with 200 us gaps, no reads -> fifo_count=3; pops return 0xAA, 0xCC, 0xF0; fifo_count=0.
- Send 0x55 with stop bit driven 0 -> framing_err=1, fifo_count=0. Assert err_clr one cycle -> framing_err=0.
- PARITY=2: send 0xCC with parity bit 1 -> parity_err=1, nothing pushed. Send 0xCC with parity bit 0 -> rd_data=0xCC.
- Send 17 frames 0x00..0x10 with no reads -> fifo_count=16, overrun_err=1, pops return 0x00..0x0F. Separately, send a frame while full with rd_en held high at completion -> pushed, no overrun.
- Robustness:
  - A 3 us low glitch on the idle line -> no frame, no flags.
  - Assert reset during data bit 4 of a frame, release, then send 0xF0 -> only 0xF0 is received; all flags 0.
